// File: rtl/mvm_seq_ctrl.sv
// mvm_seq_ctrl: load/clear/run sequencer for the 8x8 matrix x vector MAC array.
// Streams host beats into the A-lane and B FIFOs, clears the accumulators,
// then issues lane-skewed FIFO reads and MAC enables and reports completion.
module mvm_seq_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LANES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [LANES-1:0] a_full,
  input  logic [LANES-1:0] a_empty,
  input  logic             b_full,
  input  logic             b_empty,
  output logic             a_wren,
  output logic             b_wren,
  output logic [LANES-1:0] a_rden,
  output logic             b_rden,
  output logic             shift_en,
  output logic             mac_clr,
  output logic [LANES-1:0] mac_en,
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic             err
);

  localparam int unsigned LC_W   = $clog2(DEPTH + 1);
  localparam int unsigned T_W    = $clog2(DEPTH + LANES);
  localparam int unsigned T_LAST = DEPTH + LANES - 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CLEAR = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [LC_W-1:0]  lc_q, lc_d;
  logic [T_W-1:0]   t_q, t_d;
  logic             err_d;
  logic             rv_d;
  logic             ld_accept;
  logic [LANES-1:0] a_rden_d;
  logic             b_rden_d;

  // Load handshake: the FIFO writes follow the accepted beat in the same cycle
  assign ld_ready  = (state_q == S_LOAD) && (lc_q < LC_W'(DEPTH));
  assign ld_accept = ld_ready & ld_valid;
  assign a_wren    = ld_accept;
  assign b_wren    = ld_accept;

  // Next-state, counter and status-flag logic
  always_comb begin
    state_d = state_q;
    lc_d    = lc_q;
    t_d     = t_q;
    err_d   = err;
    rv_d    = result_valid;
    if (abort) begin
      state_d = S_IDLE;
      rv_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            lc_d    = '0;
            err_d   = 1'b0;
            rv_d    = 1'b0;
          end
        end
        S_LOAD: begin
          if (ld_accept) begin
            lc_d = lc_q + LC_W'(1);
            if ((|a_full) || b_full) err_d = 1'b1;
            if (lc_q == LC_W'(DEPTH - 1)) state_d = S_CLEAR;
          end
        end
        S_CLEAR: begin
          // every FIFO must hold a full load by the time accumulators clear
          if (!((&a_full) && b_full)) err_d = 1'b1;
          t_d     = '0;
          state_d = S_RUN;
        end
        S_RUN: begin
          if ((|(a_rden & a_empty)) || (b_rden && b_empty)) err_d = 1'b1;
          if (t_q == T_W'(T_LAST)) state_d = S_DRAIN;
          else                     t_d     = t_q + T_W'(1);
        end
        S_DRAIN: state_d = S_DONE;
        S_DONE: begin
          rv_d    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Read-enable pattern for the coming cycle: lane i lags lane 0 by i cycles
  always_comb begin
    a_rden_d = '0;
    b_rden_d = 1'b0;
    if (state_d == S_RUN) begin
      b_rden_d = (32'(t_d) < DEPTH);
      for (int unsigned i = 0; i < LANES; i++) begin
        a_rden_d[i] = (32'(t_d) >= i) && (32'(t_d) < i + DEPTH);
      end
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lc_q         <= '0;
      t_q          <= '0;
      a_rden       <= '0;
      b_rden       <= 1'b0;
      shift_en     <= 1'b0;
      mac_clr      <= 1'b0;
      mac_en       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      lc_q         <= lc_d;
      t_q          <= t_d;
      a_rden       <= a_rden_d;
      b_rden       <= b_rden_d;
      shift_en     <= b_rden_d;
      mac_clr      <= (state_d == S_CLEAR);
      // MAC sees FIFO data one cycle after the read
      mac_en       <= abort ? '0 : a_rden;
      busy         <= (state_d != S_IDLE);
      done         <= (state_d == S_DONE);
      result_valid <= rv_d;
      err          <= err_d;
    end
  end

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// Directed testbench for mvm_seq_ctrl with a behavioural FIFO occupancy model.
module tb_mvm_seq_ctrl;

  localparam int DEPTH = 8;
  localparam int LANES = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             ld_valid = 1'b0;
  logic             ld_ready;
  logic [LANES-1:0] a_full, a_empty;
  logic             b_full, b_empty;
  logic             a_wren, b_wren;
  logic [LANES-1:0] a_rden;
  logic             b_rden, shift_en, mac_clr;
  logic [LANES-1:0] mac_en;
  logic             busy, done, result_valid, err;

  int n_checks = 0;
  int n_fail   = 0;

  // Status overrides used to provoke error conditions
  logic bfull_kill = 1'b0;
  logic e3_force   = 1'b0;

  int a_cnt [LANES];
  int b_cnt;

  typedef struct {
    int done_cyc;
    int clr_cyc;
    int mac_tot;
    int l0_first;
    int l7_first;
    int beats;
    int err_first;
    int busy_n;
    int err_c1;
    int post_act;
  } job_t;

  job_t r;

  mvm_seq_ctrl #(.DEPTH(DEPTH), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .a_full(a_full), .a_empty(a_empty), .b_full(b_full), .b_empty(b_empty),
    .a_wren(a_wren), .b_wren(b_wren), .a_rden(a_rden), .b_rden(b_rden),
    .shift_en(shift_en), .mac_clr(mac_clr), .mac_en(mac_en),
    .busy(busy), .done(done), .result_valid(result_valid), .err(err)
  );

  always #5 clk = ~clk;

  // Ideal FIFO occupancy model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) a_cnt[i] <= 0;
      b_cnt <= 0;
    end else begin
      for (int i = 0; i < LANES; i++) a_cnt[i] <= a_cnt[i] + int'(a_wren) - int'(a_rden[i]);
      b_cnt <= b_cnt + int'(b_wren) - int'(b_rden);
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      a_full[i]  = (a_cnt[i] == DEPTH);
      a_empty[i] = (a_cnt[i] == 0) || ((i == 3) && e3_force);
    end
    b_full  = (b_cnt == DEPTH) && !bfull_kill;
    b_empty = (b_cnt == 0);
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int all_outs();
    return int'({ld_ready, a_wren, b_wren, a_rden, b_rden, shift_en, mac_clr,
                 mac_en, busy, done, result_valid, err});
  endfunction

  // Start a job at c0 and observe it cycle by cycle (bounded at 60 cycles)
  task automatic run_job(input bit gap, input int abort_cyc, output job_t j);
    j.done_cyc = -1; j.clr_cyc = -1; j.mac_tot = 0; j.l0_first = -1;
    j.l7_first = -1; j.beats = 0; j.err_first = -1; j.busy_n = 0;
    j.err_c1 = -1; j.post_act = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      ld_valid = gap ? (cyc % 2 == 0) : 1'b1;
      if (cyc == abort_cyc) begin
        abort = 1'b1;
        start = 1'b1;
      end
      @(negedge clk);
      if (cyc == 1) j.err_c1 = int'(err);
      if (a_wren) j.beats++;
      if (mac_clr && j.clr_cyc < 0) j.clr_cyc = cyc;
      if (busy) j.busy_n++;
      if (err && j.err_first < 0) j.err_first = cyc;
      for (int i = 0; i < LANES; i++) if (mac_en[i]) j.mac_tot++;
      if (mac_en[0] && j.l0_first < 0) j.l0_first = cyc;
      if (mac_en[LANES-1] && j.l7_first < 0) j.l7_first = cyc;
      if (done && j.done_cyc < 0) j.done_cyc = cyc;
      if (abort_cyc > 0 && cyc > abort_cyc)
        j.post_act |= int'((|a_rden) | (|mac_en) | b_rden | shift_en | busy | done | result_valid);
      tick();
      abort = 1'b0;
      start = 1'b0;
      if (j.done_cyc > 0 || (abort_cyc > 0 && cyc >= abort_cyc + 8)) break;
    end
    ld_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    tick();
    check("idle_ld_ready", int'(ld_ready), 0);

    // Reset asserted mid-RUN at t=5 (c15)
    start = 1'b1; ld_valid = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    check("midrun_busy", int'(busy), 1);
    check("midrun_b_rden", int'(b_rden), 1);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", all_outs(), 0);
    ld_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Nominal job, continuous load stream
    run_job(1'b0, 0, r);
    check("nom_done_cyc", r.done_cyc, 26);
    check("nom_clr_cyc", r.clr_cyc, 9);
    check("nom_beats", r.beats, 8);
    check("nom_mac_pulses", r.mac_tot, 64);
    check("nom_lane0_first", r.l0_first, 11);
    check("nom_lane7_first", r.l7_first, 18);
    check("nom_busy_cycles", r.busy_n, 26);
    check("nom_err_seen", r.err_first, -1);
    check("nom_result_valid", int'(result_valid), 1);
    check("nom_busy_after", int'(busy), 0);
    check("nom_err_after", int'(err), 0);

    // Load stream with gaps: beats on even cycles only
    run_job(1'b1, 0, r);
    check("gap_beats", r.beats, 8);
    check("gap_clr_cyc", r.clr_cyc, 17);
    check("gap_done_cyc", r.done_cyc, 34);
    check("gap_mac_pulses", r.mac_tot, 64);
    check("gap_lane7_first", r.l7_first, 26);
    check("gap_err_seen", r.err_first, -1);
    check("gap_result_valid", int'(result_valid), 1);

    // B FIFO never reports full at CLEAR
    bfull_kill = 1'b1;
    run_job(1'b0, 0, r);
    bfull_kill = 1'b0;
    check("bfull_err_first", r.err_first, 10);
    check("bfull_done_cyc", r.done_cyc, 26);
    check("bfull_err_after", int'(err), 1);
    check("bfull_result_valid", int'(result_valid), 1);

    // Lane 3 reports empty while being read; start must clear the old error
    e3_force = 1'b1;
    run_job(1'b0, 0, r);
    e3_force = 1'b0;
    check("e3_err_c1", r.err_c1, 0);
    check("e3_err_first", r.err_first, 14);
    check("e3_done_cyc", r.done_cyc, 26);
    check("e3_err_after", int'(err), 1);

    // Next clean job clears the error
    run_job(1'b0, 0, r);
    check("clean_err_c1", r.err_c1, 0);
    check("clean_done_cyc", r.done_cyc, 26);
    check("clean_err_after", int'(err), 0);

    // Abort at t=7 with start also high
    run_job(1'b0, 17, r);
    check("abort_done_seen", r.done_cyc, -1);
    check("abort_post_activity", r.post_act, 0);
    check("abort_result_valid", int'(result_valid), 0);
    check("abort_err_kept", int'(err), 0);
    check("abort_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mvm_seq_ctrl.md
# mvm_seq_ctrl

Sequencer for the 8×8 matrix × 8×1 vector MAC datapath. It accepts a host load stream, writes the A-lane and B FIFOs, and issues the MAC clear. It then drives per-lane skewed FIFO read enables, the B shift-register advance and the per-lane MAC enables, and reports completion and errors. It sits between the host/testbench and the FIFO + MAC array and holds no datapath storage.

## Interface
Parameters:
- DEPTH, 8, entries per FIFO / vector length (beats per load)
- LANES, 8, number of A FIFOs / MAC lanes

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a load+compute job; honoured only in IDLE
- abort  in  1  synchronous abort; returns to IDLE from any state
- ld_valid  in  1  host load beat valid (one A column slice + one B element)
- ld_ready  out  1  controller accepts load beat
- a_full, a_empty  in  LANES  per-lane A FIFO status
- b_full, b_empty  in  1  B FIFO status
- a_wren  out  1  write all A FIFOs (shared)
- b_wren  out  1  write B FIFO
- a_rden  out  LANES  per-lane A FIFO read enable
- b_rden  out  1  B FIFO read enable
- shift_en  out  1  advance B shift register
- mac_clr  out  1  clear all MAC accumulators
- mac_en  out  LANES  per-lane MAC enable
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse
- result_valid  out  1  MAC outputs hold a finished result
- err  out  1  sticky error (overflow/underflow/incomplete load)

## Operation
- States: IDLE, LOAD, CLEAR, RUN, DRAIN, DONE.
- IDLE: ld_ready=0. start=1 → LOAD, load count lc←0, err←0, result_valid←0.
- LOAD:
  - ld_ready = (lc<DEPTH).
  - Accepted beat = ld_valid & ld_ready. a_wren = b_wren = accepted beat (combinational, same cycle); lc++.
  - Accepted beat while any a_full or b_full is 1 → err←1 (write still issued).
  - lc==DEPTH → CLEAR. err←1 on entry to CLEAR unless all a_full and b_full are 1 in that cycle.
- CLEAR: mac_clr=1 for exactly one cycle → RUN, run count t←0.
- RUN: t counts 0..DEPTH+LANES-2 (0..14 default), then → DRAIN.
  - b_rden = shift_en = (t<DEPTH).
  - a_rden[i] = (i ≤ t < i+DEPTH): lane i starts i cycles after lane 0.
  - mac_en[i] = a_rden[i] registered one cycle (FIFO read latency 1).
  - Any a_rden[i] with a_empty[i]=1, or b_rden with b_empty=1 → err←1 (enable still issued).
- DRAIN: one cycle; carries the final mac_en[LANES-1] pulse → DONE.
- DONE: done=1 one cycle; result_valid←1 (held until next accepted start or abort) → IDLE.
- abort=1: next state IDLE; all enables/wren/rden/mac_en deassert next cycle; result_valid←0; err unchanged; abort has priority over start.
- start outside IDLE: ignored.

## Timing
- Reset: state IDLE, all outputs 0, counters 0, err 0, result_valid 0.
- Outputs a_wren, b_wren and ld_ready are combinational from state/lc/ld_valid. All other outputs are registered or decoded from state/t.
- Latency (default, host streaming ld_valid continuously): start@c0 → LOAD c1..c8 (8 beats) → CLEAR c9 → RUN c10..c24 → DRAIN c25 → DONE c26 (done=1); busy high c1..c26.
- Per-lane timing: mac_en[i] high exactly DEPTH cycles, starting c11+i; total mac_en pulses per job = DEPTH×LANES.
- Load gaps: ld_valid=0 stalls LOAD indefinitely, with no timeout.

## Test plan
- Reset mid-RUN (rst_n low at t=5) → all outputs 0 immediately; IDLE; next start runs a normal job.
- Nominal job, continuous ld_valid, status inputs mirror ideal FIFOs → done at c26, 64 mac_en pulses, lane 7 first enable c18, err=0, result_valid=1 after.
- ld_valid toggling every other cycle → 8 beats accepted over 16 cycles, CLEAR follows 8th beat, outputs identical thereafter.
- b_full held 0 through CLEAR → err=1 at CLEAR, sequence still completes, done pulses.
- a_empty[3] forced 1 during RUN → err=1; start for next job clears err.
- abort at t=7 in RUN, with start also high → IDLE next cycle, a_rden/mac_en=0, result_valid=0, no done pulse, start ignored.
